avg_channel_scheduler: RTL and testbench
========================================

Name: avg_channel_scheduler

Overview:
- Time-shares one 2-tap averaging datapath, y = (x[n] + x[n-1]) >>> 1, among NCH independent sample streams.
- A round-robin arbiter grants at most one requester per cycle and keeps a per-channel previous-sample history.
- Emits channel-tagged averaged results through the same 2-stage sum/shift pipeline with a CE strobe.
- Sits between multiple ADC/decimator channel front ends and the downstream per-channel sinks.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- DW, 8, sample width in bits, signed two's complement.
- CW, $clog2(NCH), width of the channel index (derived; do not override).

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, synchronous, active-low.
- i_req  input  NCH  per-channel request; bit k is held high with its data until acked.
- i_data  input  NCH*DW  packed samples; channel k occupies [k*DW +: DW].
- i_clear  input  1  clears all channel histories to 0.
- o_ack  output  NCH  one-hot grant, combinational; sample k is consumed on the clk edge where o_ack[k]=1.
- o_data  output  DW  signed averaged result.
- o_ch  output  CW  channel index of o_data.
- o_ce  output  1  one-cycle strobe; o_data and o_ch are valid.

Behaviour:
- Reset (reset_n=0 at an edge):
  - o_data=0, o_ch=0, o_ce=0.
  - Internal sum_ce=0, rr_ptr=0, all hist[k]=0, sum_ff=0, ch_ff=0.
  - In-flight pipeline contents are discarded.
  - o_ack is forced to 0 while reset_n=0.
- Arbitration:
  - Grant the first k with i_req[k]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod NCH.
  - o_ack is one-hot or zero.
  - On a grant to channel g, rr_ptr <= (g+1) mod NCH.
  - With no grant, rr_ptr holds.
  - A lone requester is granted every cycle; there is no bubble.
- Stage A (edge of grant g, sample x):
  - sum_ff <= sign_ext(x) + sign_ext(hist[g]), DW+1 bits, so no overflow.
  - hist[g] <= x; ch_ff <= g; sum_ce <= 1.
  - With no grant: sum_ce <= 0, and sum_ff/ch_ff hold.
- Back-to-back grants to the same channel: stage A reads hist[g] registered before the edge, which is the previous sample by construction. No forwarding is needed.
- Stage B: when sum_ce=1, o_data <= sum_ff[DW:1] (arithmetic shift, floor toward −inf) and o_ch <= ch_ff. o_ce <= sum_ce.
- Hold: o_data and o_ch hold when o_ce=0.
- Latency: o_ce asserts exactly 2 edges after the grant edge. Throughput is 1 result per cycle.
- Result ordering equals grant ordering.
- i_clear=1 at an edge:
  - All hist[k] <= 0.
  - o_ack forced to 0 that cycle (no grant), and rr_ptr holds.
  - Stage A/B results already in flight complete normally.
- Only hist and rr_ptr are channel-state; an unrequested channel's history persists indefinitely.
- Boundaries:
  - Max positive: (2^(DW-1)-1) + same gives 2^(DW-1)-1.
  - Min negative: -2^(DW-1) + same gives -2^(DW-1).
  - rr_ptr wraps NCH-1 → 0.
- i_data on non-granted channels is ignored.
- X on i_data of an unrequested channel must not propagate.

Test Plan:
- Reset, then ch0 alone presents 10, then 20 (held until ack) → o_ce pulses 2 cycles after each ack; (o_ch, o_data) = (0, 5), then (0, 15).
- From reset, all four i_req held high with ch k data = 4*(k+1) → acks in order 0,1,2,3,0,1…; first results (0,2), (1,4), (2,6), (3,8); second pass (0,4); o_ce high continuously after 2-cycle fill.
- ch2 sends −100 then −101 → (2, −50), (2, −101); ch1 sends 127, 127 → (1, 63), (1, 127); ch3 sends −128, −128 → (3, −64), (3, −128).
- ch1 sends 40 → result 20; assert i_clear one cycle with i_req[1]=1 → no ack that cycle; ch1 next sends 40 → result 20, not 40.
- Mid-stream reset: grant ch0 with 50 after history 30, drop reset_n on the following edge → o_ce stays 0 for that sample; after release ch0 sends 8 → result 4 (history 0).
- i_req = 0b1010 with rr_ptr=0 → ack ch1, then ch3, then ch1; never ch0/ch2; data on ch0/ch2 = 'x ignored.

Source files
------------

// File: rtl/avg_channel_scheduler_if.sv
// avg_channel_scheduler_if: request/sample bus and tagged result bus of the scheduler.
// Ports (master = channel front ends + sinks, slave = scheduler):
//   i_req/i_data/i_clear -> scheduler; o_ack/o_data/o_ch/o_ce <- scheduler.
interface avg_channel_scheduler_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]        i_req;
  logic [NCH*DW-1:0]     i_data;
  logic                  i_clear;
  logic [NCH-1:0]        o_ack;
  logic signed [DW-1:0]  o_data;
  logic [CW-1:0]         o_ch;
  logic                  o_ce;

  modport master (
    output i_req, i_data, i_clear,
    input  o_ack, o_data, o_ch, o_ce
  );

  modport slave (
    input  i_req, i_data, i_clear,
    output o_ack, o_data, o_ch, o_ce
  );
endinterface

// File: rtl/avg_channel_scheduler.sv
// avg_channel_scheduler: round-robin shares one y=(x[n]+x[n-1])>>>1 datapath across NCH channels.
// Latency 2 edges from grant edge to o_ce; one result per cycle. Backpressure: a requester
// holds i_req/i_data until o_ack; i_clear suppresses grants for that cycle.
// Ports: clk, reset_n (sync, active-low), bus (slave side of avg_channel_scheduler_if).
module avg_channel_scheduler #(
  parameter  int NCH = 4,
  parameter  int DW  = 8,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  avg_channel_scheduler_if.slave  bus
);

  logic [CW-1:0]        rr_ptr;
  logic [DW-1:0]        hist [NCH];
  logic [DW:0]          sum_ff;
  logic [CW-1:0]        ch_ff;
  logic                 sum_ce;
  logic signed [DW-1:0] out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_ce;

  logic [DW-1:0]        samples [NCH];
  logic [NCH-1:0]       ack;
  logic                 grant_vld;
  logic [CW-1:0]        grant_idx;
  logic [CW-1:0]        rr_nxt;
  logic [DW-1:0]        x_sel;
  logic [DW-1:0]        h_sel;
  logic [DW:0]          sum_nxt;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      samples[k] = bus.i_data[k*DW +: DW];
    end
  end

  // Scan starting at rr_ptr; the first requester found wins.
  always_comb begin
    int            pos;
    logic [CW-1:0] idx;
    ack       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = 0;
    idx       = '0;
    if (reset_n && !bus.i_clear) begin
      for (int i = 0; i < NCH; i++) begin
        pos = int'(rr_ptr) + i;
        if (pos >= NCH) pos = pos - NCH;
        idx = CW'(pos);
        if (!grant_vld && bus.i_req[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
      if (grant_vld) ack[grant_idx] = 1'b1;
    end
  end

  // Only the granted channel's sample reaches the adder, so X on idle lanes is never stored.
  always_comb begin
    x_sel   = samples[grant_idx];
    h_sel   = hist[grant_idx];
    sum_nxt = {x_sel[DW-1], x_sel} + {h_sel[DW-1], h_sel};
    rr_nxt  = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      sum_ff   <= '0;
      ch_ff    <= '0;
      sum_ce   <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      out_ce   <= 1'b0;
      for (int k = 0; k < NCH; k++) hist[k] <= '0;
    end else begin
      // Stage A: hist read here is the pre-edge value, i.e. the previous sample of
      // that channel even for back-to-back grants.
      sum_ce <= grant_vld;
      if (grant_vld) begin
        sum_ff <= sum_nxt;
        ch_ff  <= grant_idx;
        rr_ptr <= rr_nxt;
      end
      if (bus.i_clear) begin
        for (int k = 0; k < NCH; k++) hist[k] <= '0;
      end else if (grant_vld) begin
        hist[grant_idx] <= x_sel;
      end
      // Stage B: dropping the LSB of the sign-extended sum is an arithmetic shift.
      out_ce <= sum_ce;
      if (sum_ce) begin
        out_data <= sum_ff[DW:1];
        out_ch   <= ch_ff;
      end
    end
  end

  assign bus.o_ack  = ack;
  assign bus.o_data = out_data;
  assign bus.o_ch   = out_ch;
  assign bus.o_ce   = out_ce;

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Directed bench for avg_channel_scheduler (NCH=4, DW=8) with hand-computed expectations.
module tb_avg_channel_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  int exp_ack2 [7] = '{1, 2, 4, 8, 1, 2, 4};
  int exp_ch2  [6] = '{0, 1, 2, 3, 0, 1};
  int exp_d2   [6] = '{2, 4, 6, 8, 4, 8};
  int exp_ack6 [3] = '{2, 8, 2};
  int exp_ch6  [3] = '{1, 3, 1};
  int exp_d6   [3] = '{1, 3, 2};

  avg_channel_scheduler_if #(.NCH(4), .DW(8)) bus ();

  avg_channel_scheduler #(.NCH(4), .DW(8)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.i_req   = '0;
    bus.i_clear = 1'b0;
    bus.i_data  = '0;
    tick();
    reset_n = 1'b1;
  endtask

  // Present one sample on a lone channel, check the grant, consume it on the edge.
  task automatic send(input string tag, input int ch, input int val);
    bus.i_req              = '0;
    bus.i_req[ch]          = 1'b1;
    bus.i_data[ch*8 +: 8]  = val[7:0];
    #1;
    chk({tag, "_ack"}, bus.o_ack, 1 << ch);
    tick();
    bus.i_req = '0;
  endtask

  task automatic one(input string tag, input int ch, input int val, input int exp_d);
    send(tag, ch, val);
    chk({tag, "_fill"}, bus.o_ce, 0);
    tick();
    chk({tag, "_ce"}, bus.o_ce, 1);
    chk({tag, "_ch"}, bus.o_ch, ch);
    chk({tag, "_data"}, bus.o_data, exp_d);
  endtask

  initial begin
    // Reset state; requests during reset must not be acked.
    reset_n     = 1'b0;
    bus.i_req   = 4'hF;
    bus.i_clear = 1'b0;
    bus.i_data  = '0;
    tick();
    tick();
    chk("rst_ack", bus.o_ack, 0);
    chk("rst_ce", bus.o_ce, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_ch", bus.o_ch, 0);
    reset_n   = 1'b1;
    bus.i_req = '0;

    // Lone channel 0: 10 then 20.
    one("t1a", 0, 10, 5);
    one("t1b", 0, 20, 15);
    tick();
    chk("t1_idle_ce", bus.o_ce, 0);
    chk("t1_hold_data", bus.o_data, 15);
    chk("t1_hold_ch", bus.o_ch, 0);

    // All four requesting from reset: strict rotation, continuous output after fill.
    do_reset();
    bus.i_req  = 4'hF;
    bus.i_data = {8'd16, 8'd12, 8'd8, 8'd4};
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t2_ack", bus.o_ack, exp_ack2[i]);
      tick();
      if (i == 0) begin
        chk("t2_fill", bus.o_ce, 0);
      end else begin
        chk("t2_ce", bus.o_ce, 1);
        chk("t2_ch", bus.o_ch, exp_ch2[i-1]);
        chk("t2_data", bus.o_data, exp_d2[i-1]);
      end
    end
    bus.i_req = '0;
    tick();
    tick();

    // Sign handling and extremes.
    do_reset();
    one("t3_neg1", 2, -100, -50);
    one("t3_neg2", 2, -101, -101);
    one("t3_max1", 1, 127, 63);
    one("t3_max2", 1, 127, 127);
    one("t3_min1", 3, -128, -64);
    one("t3_min2", 3, -128, -128);

    // Clear: no grant that cycle, history back to zero.
    do_reset();
    one("t4a", 1, 40, 20);
    bus.i_req             = 4'b0010;
    bus.i_data[15:8]      = 8'd40;
    bus.i_clear           = 1'b1;
    #1;
    chk("t4_clr_ack", bus.o_ack, 0);
    tick();
    bus.i_clear = 1'b0;
    bus.i_req   = '0;
    chk("t4_clr_ce0", bus.o_ce, 0);
    tick();
    chk("t4_clr_ce1", bus.o_ce, 0);
    one("t4b", 1, 40, 20);

    // Reset while a sample is in flight.
    do_reset();
    one("t5a", 0, 30, 15);
    send("t5b", 0, 50);
    reset_n = 1'b0;
    tick();
    chk("t5_rst_ce", bus.o_ce, 0);
    chk("t5_rst_data", bus.o_data, 0);
    tick();
    chk("t5_rst_ce2", bus.o_ce, 0);
    reset_n = 1'b1;
    one("t5c", 0, 8, 4);

    // Sparse requesters with X on idle lanes.
    do_reset();
    bus.i_data         = 'x;
    bus.i_data[15:8]   = 8'd2;
    bus.i_data[31:24]  = 8'd6;
    bus.i_req          = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_ack", bus.o_ack, exp_ack6[i]);
      tick();
      if (i > 0) begin
        chk("t6_ce", bus.o_ce, 1);
        chk("t6_ch", bus.o_ch, exp_ch6[i-1]);
        chk("t6_data", bus.o_data, exp_d6[i-1]);
      end
    end
    bus.i_req = '0;
    tick();
    chk("t6_ce_last", bus.o_ce, 1);
    chk("t6_ch_last", bus.o_ch, exp_ch6[2]);
    chk("t6_data_last", bus.o_data, exp_d6[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
